// File: rtl/udp_rx.sv
// udp_rx: UDP receive parser. Takes the IP payload byte stream (starting at
// the UDP header), parses the 8-byte header, filters on destination port and
// forwards the UDP payload one cycle after it arrives, with length, source
// port and a malformed-datagram error pulse.
module udp_rx #(
   parameter logic [15:0] P_LOCAL_PORT = 16'd8080,
   parameter int          P_PORT_CHECK = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_ip_data,
   input  logic        i_ip_valid,
   input  logic        i_ip_last,
   output logic [7:0]  o_udp_data,
   output logic        o_udp_valid,
   output logic        o_udp_last,
   output logic [15:0] o_udp_len,
   output logic [15:0] o_src_port,
   output logic        o_udp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HEAD = 2'd1,
      S_DATA = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  hdr_cnt_q, hdr_cnt_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        last_q, last_d;
   logic        err_q, err_d;
   logic [15:0] ulen_q, ulen_d;
   logic [15:0] usrc_q, usrc_d;
   logic        is_final;
   logic        port_ok;

   // The payload byte that completes the advertised length.
   assign is_final = (cnt_q == (ulen_q - 16'd1));
   // Destination port filter; disabled when port checking is off.
   assign port_ok  = (P_PORT_CHECK == 0) || (dst_q == P_LOCAL_PORT);

   // Next-state, header capture and registered-output computation.
   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      err_d     = 1'b0;
      ulen_d    = ulen_q;
      usrc_d    = usrc_q;
      if (i_ip_valid) begin
         case (state_q)
            S_IDLE: begin
               // Header byte 0 is the source-port MSB.
               src_d     = {i_ip_data, 8'h00};
               hdr_cnt_d = 3'd1;
               if (i_ip_last) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_HEAD;
               end
            end
            S_HEAD: begin
               case (hdr_cnt_q)
                  3'd1:    src_d[7:0]  = i_ip_data;
                  3'd2:    dst_d[15:8] = i_ip_data;
                  3'd3:    dst_d[7:0]  = i_ip_data;
                  3'd4:    len_d[15:8] = i_ip_data;
                  3'd5:    len_d[7:0]  = i_ip_data;
                  default: ;
               endcase
               hdr_cnt_d = hdr_cnt_q + 3'd1;
               if (hdr_cnt_q == 3'd7) begin
                  // Checksum (bytes 6-7) is not verified; header is complete.
                  cnt_d = 16'd0;
                  if (len_q < 16'd8) begin
                     err_d   = 1'b1;
                     state_d = i_ip_last ? S_IDLE : S_DROP;
                  end else if (!port_ok || (len_q == 16'd8)) begin
                     state_d = i_ip_last ? S_IDLE : S_DROP;
                  end else if (i_ip_last) begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     ulen_d  = len_q - 16'd8;
                     usrc_d  = src_q;
                  end
               end else if (i_ip_last) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_DATA: begin
               valid_d = 1'b1;
               data_d  = i_ip_data;
               cnt_d   = cnt_q + 16'd1;
               last_d  = is_final | i_ip_last;
               // Frame ended before the advertised length was delivered.
               err_d   = i_ip_last & ~is_final;
               if (i_ip_last) begin
                  state_d = S_IDLE;
               end else if (is_final) begin
                  // Anything after the payload is Ethernet padding.
                  state_d = S_DROP;
               end
            end
            S_DROP: begin
               if (i_ip_last) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= S_IDLE;
         hdr_cnt_q <= 3'd0;
         src_q     <= 16'd0;
         dst_q     <= 16'd0;
         len_q     <= 16'd0;
         cnt_q     <= 16'd0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
         ulen_q    <= 16'd0;
         usrc_q    <= 16'd0;
      end else begin
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         err_q     <= err_d;
         ulen_q    <= ulen_d;
         usrc_q    <= usrc_d;
      end
   end

   assign o_udp_data  = data_q;
   assign o_udp_valid = valid_q;
   assign o_udp_last  = last_q;
   assign o_udp_len   = ulen_q;
   assign o_src_port  = usrc_q;
   assign o_udp_err   = err_q;

endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: directed frames against a frame-level model of udp_rx, with a
// per-cycle comparator and a few literal checks on observed outputs.
module tb_udp_rx;

   localparam logic [15:0] LOCAL = 16'd8080;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int          tag;
      bit          v;
      logic [7:0]  d;
      bit          l;
      bit          e;
      logic [15:0] len;
      logic [15:0] src;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [7:0]  i_ip_data = 8'd0;
   logic        i_ip_valid = 1'b0;
   logic        i_ip_last = 1'b0;
   logic [7:0]  o_udp_data;
   logic        o_udp_valid;
   logic        o_udp_last;
   logic [15:0] o_udp_len;
   logic [15:0] o_src_port;
   logic        o_udp_err;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   exp_t mq[$];
   bq_t  obs_q;
   int   last_cnt = 0;
   int   err_cnt = 0;
   logic [15:0] obs_len = 16'd0;
   logic [15:0] obs_src = 16'd0;

   udp_rx #(.P_LOCAL_PORT(LOCAL), .P_PORT_CHECK(1)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_ip_data  (i_ip_data),
      .i_ip_valid (i_ip_valid),
      .i_ip_last  (i_ip_last),
      .o_udp_data (o_udp_data),
      .o_udp_valid(o_udp_valid),
      .o_udp_last (o_udp_last),
      .o_udp_len  (o_udp_len),
      .o_src_port (o_src_port),
      .o_udp_err  (o_udp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Build a datagram: header, npay incrementing payload bytes from base, npad zero pads.
   function automatic bq_t mk(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                              input int npay, input logic [7:0] base, input int npad);
      bq_t f;
      f = {s[15:8], s[7:0], d[15:8], d[7:0], l[15:8], l[7:0], 8'h5A, 8'hC3};
      for (int k = 0; k < npay; k++) f.push_back(base + 8'(k));
      for (int k = 0; k < npad; k++) f.push_back(8'h00);
      return f;
   endfunction

   // Frame-level model: what each input byte of the frame must produce one cycle later.
   function automatic void model_frame(input bq_t f);
      exp_t z;
      int n, p, m;
      logic [15:0] s, d, l;
      z = '{default: 0};
      mq.delete();
      n = f.size();
      for (int i = 0; i < n; i++) mq.push_back(z);
      if (n < 8) begin
         mq[n-1].e = 1'b1;
         return;
      end
      s = {f[0], f[1]};
      d = {f[2], f[3]};
      l = {f[4], f[5]};
      if (l < 16'd8) begin
         mq[7].e = 1'b1;
      end else if (d != LOCAL || l == 16'd8) begin
         // filtered or empty: nothing
      end else begin
         p = int'(l) - 8;
         if (n == 8) begin
            mq[7].e = 1'b1;
         end else begin
            m = (n - 8 < p) ? n - 8 : p;
            for (int k = 0; k < m; k++) begin
               mq[8+k].v   = 1'b1;
               mq[8+k].d   = f[8+k];
               mq[8+k].len = 16'(p);
               mq[8+k].src = s;
            end
            mq[8+m-1].l = 1'b1;
            if (n - 8 < p) mq[8+m-1].e = 1'b1;
         end
      end
   endfunction

   task automatic drive(input bit v, input logic [7:0] d, input bit l, input exp_t e);
      @(posedge clk);
      #1;
      i_ip_valid = v;
      i_ip_data  = d;
      i_ip_last  = l;
      e.tag = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      exp_t z;
      z = '{default: 0};
      drive(1'b0, 8'h00, 1'b0, z);
   endtask

   task automatic send_frame(input bq_t f, input bit gap, input int cut);
      int n;
      model_frame(f);
      n = (cut > 0) ? cut : f.size();
      for (int i = 0; i < n; i++) begin
         drive(1'b1, f[i], (i == f.size() - 1), mq[i]);
         if (gap) idle();
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 8) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic clear_obs();
      obs_q.delete();
      last_cnt = 0;
      err_cnt  = 0;
   endtask

   // Per-cycle comparison of DUT outputs against the model's expectations.
   always @(negedge clk) begin
      if (i_rst) begin
         if (o_udp_valid) obs_q.push_back(o_udp_data);
         if (o_udp_last) begin
            last_cnt++;
            obs_len = o_udp_len;
            obs_src = o_src_port;
         end
         if (o_udp_err) err_cnt++;
         while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            check("stale_tag", exp_q[0].tag, cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("valid", o_udp_valid, e.v);
            if (e.v) begin
               check("data", o_udp_data, e.d);
               check("len", o_udp_len, e.len);
               check("src_port", o_src_port, e.src);
            end
            check("last", o_udp_last, e.l);
            check("err", o_udp_err, e.e);
         end
      end
   end

   initial begin
      bq_t f;
      repeat (3) @(posedge clk);
      // Reset state
      check("rst_valid", o_udp_valid, 0);
      check("rst_len", o_udp_len, 0);
      check("rst_err", o_udp_err, 0);
      #2;
      i_rst = 1'b1;

      // Basic frame on the local port, i_ip_last on the final payload byte
      clear_obs();
      send_frame(mk(16'h1234, LOCAL, 16'd12, 4, 8'hA1, 0), 1'b0, 0);
      idle();
      drain();
      check("f1_count", obs_q.size(), 4);
      if (obs_q.size() == 4) check("f1_bytes", {obs_q[0], obs_q[1], obs_q[2], obs_q[3]}, 32'hA1A2A3A4);
      check("f1_last_cnt", last_cnt, 1);
      check("f1_err_cnt", err_cnt, 0);
      check("f1_len", obs_len, 16'd4);
      check("f1_src", obs_src, 16'h1234);

      // Padded frame followed back-to-back by the plain frame
      clear_obs();
      send_frame(mk(16'h1234, LOCAL, 16'd12, 4, 8'hA1, 6), 1'b0, 0);
      send_frame(mk(16'h1234, LOCAL, 16'd12, 4, 8'hA1, 0), 1'b0, 0);
      idle();
      drain();
      check("pad_count", obs_q.size(), 8);
      check("pad_err_cnt", err_cnt, 0);

      // Foreign port dropped, then a local-port frame
      clear_obs();
      send_frame(mk(16'h1234, 16'd9000, 16'd12, 4, 8'hA1, 0), 1'b0, 0);
      idle();
      drain();
      check("port_count", obs_q.size(), 0);
      check("port_err_cnt", err_cnt, 0);
      send_frame(mk(16'h5678, LOCAL, 16'd12, 4, 8'hB1, 0), 1'b0, 0);
      idle();
      drain();
      check("port_next_count", obs_q.size(), 4);
      check("port_next_src", obs_src, 16'h5678);

      // Truncated datagram: length 20 but only 5 payload bytes
      clear_obs();
      send_frame(mk(16'h4321, LOCAL, 16'd20, 5, 8'hC1, 0), 1'b0, 0);
      idle();
      drain();
      check("trunc_count", obs_q.size(), 5);
      check("trunc_last_cnt", last_cnt, 1);
      check("trunc_err_cnt", err_cnt, 1);
      check("trunc_len", obs_len, 16'd12);

      // Length 6: malformed, rest dropped
      clear_obs();
      send_frame(mk(16'h1111, LOCAL, 16'd6, 3, 8'h55, 0), 1'b0, 0);
      idle();
      drain();
      check("len6_err_cnt", err_cnt, 1);
      check("len6_count", obs_q.size(), 0);

      // Length 8: empty payload, silent drop
      clear_obs();
      send_frame(mk(16'h1111, LOCAL, 16'd8, 0, 8'h00, 2), 1'b0, 0);
      idle();
      drain();
      check("len8_err_cnt", err_cnt, 0);
      check("len8_count", obs_q.size(), 0);

      // Early end inside the header
      clear_obs();
      f = mk(16'h1111, LOCAL, 16'd12, 0, 8'h00, 0);
      f = f[0:4];
      send_frame(f, 1'b0, 0);
      idle();
      drain();
      check("hdr_early_err_cnt", err_cnt, 1);

      // Bubbles on every other cycle
      clear_obs();
      send_frame(mk(16'hABCD, LOCAL, 16'd12, 4, 8'hD1, 0), 1'b1, 0);
      idle();
      drain();
      check("gap_count", obs_q.size(), 4);
      if (obs_q.size() == 4) check("gap_bytes", {obs_q[0], obs_q[1], obs_q[2], obs_q[3]}, 32'hD1D2D3D4);

      // Reset asserted mid-payload
      send_frame(mk(16'h2222, LOCAL, 16'd12, 4, 8'hE1, 0), 1'b0, 10);
      @(posedge clk);
      #1;
      i_ip_valid = 1'b0;
      i_ip_last  = 1'b0;
      @(negedge clk);
      #1;
      check("pre_rst_len", o_udp_len, 16'd4);
      i_rst = 1'b0;
      #1;
      check("arst_valid", o_udp_valid, 0);
      check("arst_data", o_udp_data, 0);
      check("arst_len", o_udp_len, 0);
      check("arst_src", o_src_port, 0);
      check("arst_last", o_udp_last, 0);
      check("arst_err", o_udp_err, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      i_rst = 1'b1;

      clear_obs();
      send_frame(mk(16'h3333, LOCAL, 16'd12, 4, 8'hF1, 0), 1'b0, 0);
      idle();
      drain();
      check("post_rst_count", obs_q.size(), 4);
      check("post_rst_src", obs_src, 16'h3333);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- UDP receive parser; the receive-direction counterpart of the UDP transmit path.
- Sits between the IP receive layer and user logic.
- Consumes the IP payload byte stream (starting at the UDP header), parses the 8-byte UDP header and filters on the destination port.
- Forwards only the UDP payload with framing, length and source port, and flags malformed datagrams.

Parameters:
- P_LOCAL_PORT, 16'd8080, UDP destination port accepted by this node.
- P_PORT_CHECK, 1, 1 = drop datagrams whose destination port differs from P_LOCAL_PORT; 0 = accept any port.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-low (0 = reset).
- i_ip_data  input  8  IP payload byte; first byte is the UDP source-port MSB.
- i_ip_valid  input  1  i_ip_data valid this cycle; may deassert mid-frame (bubbles).
- i_ip_last  input  1  qualifies with i_ip_valid; marks the final IP payload byte.
- o_udp_data  output  8  payload byte.
- o_udp_valid  output  1  o_udp_data valid.
- o_udp_last  output  1  last payload byte of the datagram.
- o_udp_len  output  16  payload length in bytes (UDP length - 8); stable from first o_udp_valid to o_udp_last.
- o_src_port  output  16  source port of the current datagram; same stability as o_udp_len.
- o_udp_err  output  1  one-cycle pulse on a malformed datagram.

Behaviour:
- Reset (i_rst=0, async): all outputs 0, state IDLE, counters 0.
- No backpressure. Every accepted input byte is processed in the cycle it arrives.
- States:
  - IDLE: first valid byte is header byte 0 -> HEAD.
  - HEAD: collects bytes 0..7, big-endian:
    - src port = bytes 0-1
    - dst port = bytes 2-3
    - UDP length = bytes 4-5
    - checksum = bytes 6-7 (ignored, not verified).
  - On header byte 7:
    - length < 8 -> DROP, with o_udp_err pulse.
    - P_PORT_CHECK=1 and dst port != P_LOCAL_PORT -> DROP, no err.
    - length == 8 (empty payload) -> DROP, no output, no err.
    - otherwise -> DATA; latch o_udp_len = length-8 and o_src_port.
  - DATA: each valid input byte is output registered, so o_udp_valid/o_udp_data follow the input byte by exactly 1 cycle.
    - 16-bit payload counter increments per byte.
    - o_udp_last is set on the byte where count == o_udp_len-1.
    - After that byte: if i_ip_last on the same byte -> IDLE; else -> DROP. Trailing bytes are Ethernet padding and are discarded without err.
  - DROP: discards valid bytes until i_ip_last -> IDLE.
- i_ip_last in any state returns the FSM to IDLE after that byte. The next valid byte starts a new header.
- Early end: i_ip_last in HEAD (before byte 7) -> o_udp_err pulse, no output. i_ip_last in DATA before count reaches o_udp_len-1 -> that byte is output with o_udp_last=1, and o_udp_err pulses in the same cycle as that o_udp_last.
- i_ip_last on header byte 7 with length > 8 -> o_udp_err, IDLE.
- Invalid cycles (i_ip_valid=0): state and counters hold; o_udp_valid=0 on the next cycle.
- o_udp_last and o_udp_err are only ever 1 for one cycle each per datagram.
- Back-to-back frames: a new header may start the cycle after i_ip_last. There is no required gap.

Test Plan:
- Port 8080, UDP length 16'd12, payload A1 A2 A3 A4, contiguous valid, i_ip_last on A4 -> 4 output bytes 1 cycle delayed, o_udp_last on A4, o_udp_len=4, o_src_port = header value, o_udp_err=0.
- Same frame with 6 padding bytes after payload (i_ip_last on last pad) -> identical output; padding not forwarded; no err.
- dst port 16'd9000, P_PORT_CHECK=1 -> no o_udp_valid, no err; next valid frame on 8080 is received correctly.
- Length field 16'd20 but i_ip_last after 5 payload bytes -> 5 bytes out, o_udp_last and o_udp_err together on byte 5.
- Length field 16'd6 -> err pulse after header byte 7, rest dropped. Length 16'd8 -> nothing output, no err.
- i_ip_valid toggling 1/0 every cycle during a 4-byte payload -> output bytes spaced identically, correct data/last. Assert i_rst=0 mid-payload -> outputs 0 immediately; after release, a new frame parses correctly.
